// File: rtl/tick_counter_chaser_if.sv
// Control/status bundle for tick_counter_chaser.
//   master : drives iEN/iCLR/iLOAD/iLOAD_VAL/iDIR/iMODE, observes outputs
//   slave  : the block itself; receives controls, drives oTICK/oWRAP/oCOUNT/oLED/oSEG
interface tick_counter_chaser_if #(
  parameter int CNT_WIDTH = 16,
  parameter int LED_WIDTH = 8,
  parameter int DIGITS    = 4
);
  logic                   iEN;
  logic                   iCLR;
  logic                   iLOAD;
  logic [CNT_WIDTH-1:0]   iLOAD_VAL;
  logic                   iDIR;
  logic [1:0]             iMODE;
  logic                   oTICK;
  logic                   oWRAP;
  logic [CNT_WIDTH-1:0]   oCOUNT;
  logic [LED_WIDTH-1:0]   oLED;
  logic [7*DIGITS-1:0]    oSEG;

  modport master (
    output iEN, iCLR, iLOAD, iLOAD_VAL, iDIR, iMODE,
    input  oTICK, oWRAP, oCOUNT, oLED, oSEG
  );

  modport slave (
    input  iEN, iCLR, iLOAD, iLOAD_VAL, iDIR, iMODE,
    output oTICK, oWRAP, oCOUNT, oLED, oSEG
  );
endinterface

// File: rtl/tick_counter_chaser.sv
// Tick divider + modulo up/down counter + one-hot LED chaser + hex 7-seg.
//   iCLK, iRST_N : clock, async active-low reset
//   bus (slave)  : iEN divider enable, iCLR sync clear, iLOAD/iLOAD_VAL
//                  counter load (saturated to CNT_MAX), iDIR 0 up / 1 down,
//                  iMODE chaser mode; oTICK/oWRAP one-cycle pulses,
//                  oCOUNT, oLED (one-hot), oSEG (active-low, 7 bits/digit).
// All of oTICK/oWRAP/oCOUNT/oLED come straight from flops.
module tick_counter_chaser #(
  parameter int CLK_DIV   = 50000000,
  parameter int CNT_WIDTH = 16,
  parameter int CNT_MAX   = 15,
  parameter int LED_WIDTH = 8,
  parameter int DIGITS    = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  tick_counter_chaser_if.slave  bus
);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SEG_BITS = 4 * DIGITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = CNT_WIDTH'(CNT_MAX);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LED_WIDTH-1:0] LED_INIT  = LED_WIDTH'(1);

  logic [DIV_W-1:0]     div_q,  div_d;
  logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
  logic [LED_WIDTH-1:0] led_q,  led_d;
  logic                 pp_right_q, pp_right_d;   // ping-pong heading right
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 tick_now;

  assign tick_now = bus.iEN && (div_q == DIV_LAST);

  always_comb begin
    div_d      = div_q;
    cnt_d      = cnt_q;
    led_d      = led_q;
    pp_right_d = pp_right_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    if (bus.iCLR) begin
      div_d      = '0;
      cnt_d      = '0;
      led_d      = LED_INIT;
      pp_right_d = 1'b0;
    end else begin
      if (bus.iEN) div_d = tick_now ? '0 : div_q + 1'b1;
      tick_d = tick_now;
      // Load beats the tick for the counter only; divider and chaser still run.
      if (bus.iLOAD) begin
        cnt_d = (bus.iLOAD_VAL > CNT_MAX_C) ? CNT_MAX_C : bus.iLOAD_VAL;
      end else if (tick_now) begin
        if (!bus.iDIR) begin
          wrap_d = (cnt_q == CNT_MAX_C);
          cnt_d  = wrap_d ? '0 : cnt_q + 1'b1;
        end else begin
          wrap_d = (cnt_q == '0);
          cnt_d  = wrap_d ? CNT_MAX_C : cnt_q - 1'b1;
        end
      end
      if (tick_now) begin
        unique case (bus.iMODE)
          2'd0: led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
          2'd1: led_d = {led_q[0], led_q[LED_WIDTH-1:1]};
          2'd2: begin
            // Bounce off an endpoint in the same step so it is lit only once.
            if (!pp_right_q) begin
              if (led_q[LED_WIDTH-1]) begin
                led_d = led_q >> 1;  pp_right_d = 1'b1;
              end else led_d = led_q << 1;
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;  pp_right_d = 1'b0;
              end else led_d = led_q >> 1;
            end
          end
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div_q      <= '0;
      cnt_q      <= '0;
      led_q      <= LED_INIT;
      pp_right_q <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      pp_right_q <= pp_right_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Size cast zero-extends or drops the upper count bits as needed.
  logic [SEG_BITS-1:0] cnt_ext;
  logic [7*DIGITS-1:0] seg;
  assign cnt_ext = SEG_BITS'(cnt_q);

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) seg[7*i +: 7] = hex7(cnt_ext[4*i +: 4]);
  end

  assign bus.oTICK  = tick_q;
  assign bus.oWRAP  = wrap_q;
  assign bus.oCOUNT = cnt_q;
  assign bus.oLED   = led_q;
  assign bus.oSEG   = seg;
endmodule

// File: tb/tb_tick_counter_chaser.sv
// Directed bench: CLK_DIV=4/CNT_WIDTH=4/CNT_MAX=5/LED_WIDTH=4/DIGITS=2,
// plus a CLK_DIV=1 instance sharing clock and reset.
module tb_tick_counter_chaser;
  logic gclk = 1'b0;
  logic grst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 gclk = ~gclk;

  tick_counter_chaser_if #(.CNT_WIDTH(4), .LED_WIDTH(4), .DIGITS(2)) b1();
  tick_counter_chaser_if #(.CNT_WIDTH(4), .LED_WIDTH(4), .DIGITS(2)) b2();

  tick_counter_chaser #(.CLK_DIV(4), .CNT_WIDTH(4), .CNT_MAX(5), .LED_WIDTH(4), .DIGITS(2))
    u_dut (.iCLK(gclk), .iRST_N(grst_n), .bus(b1));
  tick_counter_chaser #(.CLK_DIV(1), .CNT_WIDTH(4), .CNT_MAX(5), .LED_WIDTH(4), .DIGITS(2))
    u_dut1 (.iCLK(gclk), .iRST_N(grst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk); #1;
  endtask

  // Steps until oTICK, returning the cycles taken; bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(); n++;
    end while (!b1.oTICK && n < 20);
  endtask

  // Hand-written DE2 codes for 0..5
  logic [6:0] seg_exp [0:5] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010};
  logic [3:0] cnt_up [0:5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
  logic [3:0] led_r0 [0:5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [3:0] led_pp [0:7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                               4'b0010, 4'b0001, 4'b0010, 4'b0100};
  logic [3:0] cnt_dn [0:2] = '{4'd5, 4'd4, 4'd3};
  logic [3:0] led_dn [0:2] = '{4'b1000, 4'b0001, 4'b0010};

  initial begin
    int n;
    grst_n = 1'b0;
    b1.iEN = 1'b1; b1.iCLR = 1'b0; b1.iLOAD = 1'b0; b1.iLOAD_VAL = '0;
    b1.iDIR = 1'b0; b1.iMODE = 2'd0;
    b2.iEN = 1'b1; b2.iCLR = 1'b0; b2.iLOAD = 1'b0; b2.iLOAD_VAL = '0;
    b2.iDIR = 1'b0; b2.iMODE = 2'd0;
    step(); step();
    chk("rst_cnt",  b1.oCOUNT, 0);
    chk("rst_led",  b1.oLED, 4'b0001);
    chk("rst_tick", b1.oTICK, 0);
    chk("rst_wrap", b1.oWRAP, 0);
    chk("rst_seg",  b1.oSEG, 14'b1000000_1000000);

    // Up count, mode 0
    grst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      chk("up_gap",  n, 4);
      chk("up_cnt",  b1.oCOUNT, cnt_up[i]);
      chk("up_wrap", b1.oWRAP, (i == 5));
      chk("up_led",  b1.oLED, led_r0[i]);
      chk("up_seg0", b1.oSEG[6:0], seg_exp[cnt_up[i]]);
      chk("up_seg1", b1.oSEG[13:7], 7'b1000000);
    end
    step();
    chk("tick_pulse", b1.oTICK, 0);
    chk("wrap_pulse", b1.oWRAP, 0);

    // Down from 0 (three more cycles brings us to the next tick)
    b1.iDIR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      if (i > 0) chk("dn_gap", n, 4);
      chk("dn_cnt",  b1.oCOUNT, cnt_dn[i]);
      chk("dn_wrap", b1.oWRAP, (i == 0));
      chk("dn_led",  b1.oLED, led_dn[i]);
    end

    // Freeze
    b1.iEN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_tick", b1.oTICK, 0);
      chk("frz_cnt",  b1.oCOUNT, 3);
      chk("frz_led",  b1.oLED, 4'b0010);
    end
    b1.iEN = 1'b1;
    wait_tick(n);
    chk("resume_gap", n, 4);
    chk("resume_cnt", b1.oCOUNT, 2);
    chk("resume_led", b1.oLED, 4'b0100);

    // Two more mode-0 ticks to reach 0001 (count 1, 0)
    wait_tick(n); wait_tick(n);
    chk("pre_pp_led", b1.oLED, 4'b0001);
    chk("pre_pp_cnt", b1.oCOUNT, 0);

    // Ping-pong
    b1.iMODE = 2'd2;
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      chk("pp_led", b1.oLED, led_pp[i]);
    end
    chk("pp_cnt", b1.oCOUNT, 4);

    // Hold
    b1.iMODE = 2'd3;
    wait_tick(n); wait_tick(n);
    chk("hold_led", b1.oLED, 4'b0100);
    chk("hold_cnt", b1.oCOUNT, 2);

    // Load saturating (div was 0 -> 1 on this edge)
    b1.iLOAD = 1'b1; b1.iLOAD_VAL = 4'd9;
    step();
    b1.iLOAD = 1'b0;
    chk("ld_sat",  b1.oCOUNT, 5);
    chk("ld_tick", b1.oTICK, 0);
    b1.iDIR = 1'b0;
    step(); step();
    chk("ld_pre_tick", b1.oTICK, 0);
    // Load on the tick edge: would otherwise wrap 5->0
    b1.iLOAD = 1'b1; b1.iLOAD_VAL = 4'd2; b1.iMODE = 2'd0;
    step();
    b1.iLOAD = 1'b0;
    chk("ldt_tick", b1.oTICK, 1);
    chk("ldt_cnt",  b1.oCOUNT, 2);
    chk("ldt_wrap", b1.oWRAP, 0);
    chk("ldt_led",  b1.oLED, 4'b1000);

    // Clear mid-interval with enable low
    step(); step();
    b1.iEN = 1'b0; b1.iCLR = 1'b1;
    step();
    b1.iCLR = 1'b0;
    chk("clr_cnt", b1.oCOUNT, 0);
    chk("clr_led", b1.oLED, 4'b0001);
    chk("clr_tick", b1.oTICK, 0);
    step(); step(); step();
    b1.iEN = 1'b1;
    wait_tick(n);
    chk("clr_gap", n, 4);
    chk("clr_cnt1", b1.oCOUNT, 1);
    chk("clr_led1", b1.oLED, 4'b0010);

    // Async reset away from any edge
    #2 grst_n = 1'b0;
    #1;
    chk("arst_tick", b1.oTICK, 0);
    chk("arst_cnt",  b1.oCOUNT, 0);
    chk("arst_led",  b1.oLED, 4'b0001);
    chk("arst_seg",  b1.oSEG, 14'b1000000_1000000);

    // CLK_DIV=1 instance
    step();
    grst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("d1_tick", b2.oTICK, 1);
      chk("d1_cnt",  b2.oCOUNT, cnt_up[i]);
      chk("d1_wrap", b2.oWRAP, (i == 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
